// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu - MEM-stage load/store unit.
//
// Accepts one EX-stage load or store at a time and issues it on a
// single-outstanding req/gnt/rvalid data-memory port. Stores are lane-shifted
// and get byte enables. Loads are shifted down from the doubleword and then
// sign- or zero-extended for write-back.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   i_valid         EX request valid; taken only while o_ready (IDLE)
//   o_ready         LSU idle and able to accept a request
//   i_mem_rd/wr     load / store select (both set = illegal)
//   i_funct3        access size/sign: B,H,W,D,BU,HU,WU (111 illegal)
//   i_addr          byte address
//   i_wdata         LSB-justified store data
//   i_rd            load destination register
//   dmem_*          data-memory request/response port
//   o_wb_valid      one-cycle pulse: load result on o_wb_rd/o_wb_data
//   o_wb_rd/data    write-back register/data, held between pulses
//   o_done          one-cycle pulse: load or store retired
//   o_exc           one-cycle pulse: misaligned or illegal request
// ---------------------------------------------------------------------------
module mem_lsu #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [4:0]        i_rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              o_wb_valid,
  output logic [4:0]        o_wb_rd,
  output logic [XLEN-1:0]   o_wb_data,
  output logic              o_done,
  output logic              o_exc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e              state_q, state_d;

  // Request latched on the accepting edge.
  logic                we_q;
  logic [XLEN-1:0]     addr_q;
  logic [XLEN/8-1:0]   be_q;
  logic [XLEN-1:0]     wdata_q;
  logic [2:0]          funct3_q;
  logic [2:0]          off_q;
  logic [4:0]          rd_q;

  // Registered output pulses and write-back holding registers.
  logic                done_q, done_d;
  logic                wb_valid_q, wb_valid_d;
  logic                exc_q, exc_d;
  logic [4:0]          wb_rd_q;
  logic [XLEN-1:0]     wb_data_q;

  // Request decode.
  logic                is_access;
  logic                illegal;
  logic                misaligned;
  logic                take;
  logic                accept;
  logic [XLEN/8-1:0]   be_base;
  logic                capture;

  // Load extraction.
  logic [XLEN-1:0]     ld_raw;
  logic [XLEN-1:0]     ld_ext;

  assign is_access = i_mem_rd | i_mem_wr;
  assign illegal   = (i_mem_rd & i_mem_wr) | (i_funct3 == 3'b111);
  assign take      = i_valid & (state_q == S_IDLE) & is_access;
  assign accept    = take & ~illegal & ~misaligned;

  // Size comes from funct3[1:0]; the unsigned variants share the signed sizes.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    misaligned = 1'b0;
    be_base    = '0;
    case (i_funct3[1:0])
      2'b00: be_base = 8'h01;
      2'b01: begin
        be_base    = 8'h03;
        misaligned = i_addr[0];
      end
      2'b10: begin
        be_base    = 8'h0F;
        misaligned = |i_addr[1:0];
      end
      default: begin
        be_base    = 8'hFF;
        misaligned = |i_addr[2:0];
      end
    endcase
  end

  // Load data: shift the addressed lane down, then extend per access type.
  always_comb begin
    ld_raw = dmem_rdata >> {off_q, 3'b000};
    ld_ext = ld_raw;
    case (funct3_q)
      3'b000:  ld_ext = {{(XLEN-8){ld_raw[7]}},   ld_raw[7:0]};
      3'b001:  ld_ext = {{(XLEN-16){ld_raw[15]}}, ld_raw[15:0]};
      3'b010:  ld_ext = {{(XLEN-32){ld_raw[31]}}, ld_raw[31:0]};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}},        ld_raw[7:0]};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}},       ld_raw[15:0]};
      3'b110:  ld_ext = {{(XLEN-32){1'b0}},       ld_raw[31:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  // Next-state and pulse logic. gnt is only looked at in REQ and rvalid only
  // in WAIT, so a response arriving alongside gnt is dropped.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    wb_valid_d = 1'b0;
    exc_d      = take & (illegal | misaligned);
    capture    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_REQ;
      end
      S_REQ: begin
        if (dmem_gnt) begin
          if (we_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          done_d     = 1'b1;
          capture    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the latched request is reset too; it drives dmem_addr/dmem_wdata
  // directly, and those must read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      done_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      exc_q      <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      wb_valid_q <= wb_valid_d;
      exc_q      <= exc_d;
      if (accept) begin
        we_q     <= i_mem_wr;
        addr_q   <= {i_addr[XLEN-1:3], 3'b000};
        be_q     <= be_base << i_addr[2:0];
        wdata_q  <= i_wdata << {i_addr[2:0], 3'b000};
        funct3_q <= i_funct3;
        off_q    <= i_addr[2:0];
        rd_q     <= i_rd;
      end
      if (capture) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= ld_ext;
      end
    end
  end

  assign o_ready    = (state_q == S_IDLE);
  assign dmem_req   = (state_q == S_REQ);
  assign dmem_we    = (state_q == S_REQ) & we_q;
  assign dmem_be    = (state_q == S_REQ) ? be_q : '0;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign o_done     = done_q;
  assign o_wb_valid = wb_valid_q;
  assign o_exc      = exc_q;
  assign o_wb_rd    = wb_rd_q;
  assign o_wb_data  = wb_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_lsu - directed self-checking bench for mem_lsu.
// Inputs change and outputs are sampled 1 ns after each rising edge; memory
// responses are driven cycle by cycle from the test tasks.
// ---------------------------------------------------------------------------
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_mem_rd = 1'b0;
  logic        i_mem_wr = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [63:0] i_addr = '0;
  logic [63:0] i_wdata = '0;
  logic [4:0]  i_rd = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [7:0]  dmem_be;
  logic [63:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [63:0] dmem_rdata = '0;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [63:0] o_wb_data;
  logic        o_done;
  logic        o_exc;

  int n_checks = 0;
  int n_errors = 0;

  mem_lsu #(.XLEN(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_mem_rd    (i_mem_rd),
    .i_mem_wr    (i_mem_wr),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_rd        (i_rd),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .o_wb_valid  (o_wb_valid),
    .o_wb_rd     (o_wb_rd),
    .o_wb_data   (o_wb_data),
    .o_done      (o_done),
    .o_exc       (o_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ready"},   o_ready,    1'b1);
    check({tag, " req"},     dmem_req,   1'b0);
    check({tag, " we"},      dmem_we,    1'b0);
    check({tag, " be"},      dmem_be,    8'h00);
    check({tag, " addr"},    dmem_addr,  64'h0);
    check({tag, " wdata"},   dmem_wdata, 64'h0);
    check({tag, " wbvalid"}, o_wb_valid, 1'b0);
    check({tag, " wbrd"},    o_wb_rd,    5'd0);
    check({tag, " wbdata"},  o_wb_data,  64'h0);
    check({tag, " done"},    o_done,     1'b0);
    check({tag, " exc"},     o_exc,      1'b0);
  endtask

  // Store with gnt already high: accept, one REQ cycle, o_done the cycle after.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] exp_be,
                          input logic [63:0] exp_wdata);
    i_valid = 1'b1; i_mem_rd = 1'b0; i_mem_wr = 1'b1;
    i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    dmem_gnt = 1'b1;
    tick();
    i_valid = 1'b0; i_mem_wr = 1'b0; i_addr = '0; i_wdata = '0; i_funct3 = '0;
    check({tag, " req"},   dmem_req,   1'b1);
    check({tag, " we"},    dmem_we,    1'b1);
    check({tag, " be"},    dmem_be,    exp_be);
    check({tag, " addr"},  dmem_addr,  {addr[63:3], 3'b000});
    check({tag, " wdata"}, dmem_wdata, exp_wdata);
    check({tag, " ready"}, o_ready,    1'b0);
    check({tag, " early done"}, o_done, 1'b0);
    tick();
    dmem_gnt = 1'b0;
    check({tag, " done"},     o_done,     1'b1);
    check({tag, " wbvalid"},  o_wb_valid, 1'b0);
    check({tag, " req off"},  dmem_req,   1'b0);
    check({tag, " be off"},   dmem_be,    8'h00);
    check({tag, " ready on"}, o_ready,    1'b1);
    tick();
    check({tag, " done pulse"}, o_done, 1'b0);
  endtask

  // Load: gnt after gnt_delay REQ cycles, rvalid in the first WAIT cycle.
  // With rv_with_gnt, rvalid (and wrong data) also accompanies gnt and must
  // be ignored.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [4:0] rd, input logic [63:0] rdata,
                         input int gnt_delay, input bit rv_with_gnt,
                         input logic [7:0] exp_be, input logic [63:0] exp_data);
    i_valid = 1'b1; i_mem_rd = 1'b1; i_mem_wr = 1'b0;
    i_funct3 = f3; i_addr = addr; i_rd = rd;
    tick();
    i_valid = 1'b0; i_mem_rd = 1'b0; i_addr = '0; i_funct3 = '0; i_rd = '0;
    for (int i = 0; i < gnt_delay; i++) begin
      check({tag, " req held"},  dmem_req,  1'b1);
      check({tag, " addr held"}, dmem_addr, {addr[63:3], 3'b000});
      check({tag, " be held"},   dmem_be,   exp_be);
      tick();
    end
    check({tag, " req"},   dmem_req,  1'b1);
    check({tag, " we"},    dmem_we,   1'b0);
    check({tag, " be"},    dmem_be,   exp_be);
    check({tag, " addr"},  dmem_addr, {addr[63:3], 3'b000});
    check({tag, " ready"}, o_ready,   1'b0);
    dmem_gnt = 1'b1;
    dmem_rvalid = rv_with_gnt;
    dmem_rdata = ~rdata;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    check({tag, " wait req"},     dmem_req,   1'b0);
    check({tag, " wait ready"},   o_ready,    1'b0);
    check({tag, " wait wbvalid"}, o_wb_valid, 1'b0);
    check({tag, " wait done"},    o_done,     1'b0);
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    check({tag, " wbvalid"}, o_wb_valid, 1'b1);
    check({tag, " done"},    o_done,     1'b1);
    check({tag, " wbdata"},  o_wb_data,  exp_data);
    check({tag, " wbrd"},    o_wb_rd,    rd);
    tick();
    check({tag, " wbvalid pulse"}, o_wb_valid, 1'b0);
    check({tag, " wbdata hold"},   o_wb_data,  exp_data);
    check({tag, " wbrd hold"},     o_wb_rd,    rd);
  endtask

  task automatic do_exc(input string tag, input logic rd_en, input logic wr_en,
                        input logic [2:0] f3, input logic [63:0] addr);
    i_valid = 1'b1; i_mem_rd = rd_en; i_mem_wr = wr_en; i_funct3 = f3; i_addr = addr;
    tick();
    i_valid = 1'b0; i_mem_rd = 1'b0; i_mem_wr = 1'b0; i_funct3 = '0; i_addr = '0;
    check({tag, " exc"},   o_exc,    1'b1);
    check({tag, " req"},   dmem_req, 1'b0);
    check({tag, " ready"}, o_ready,  1'b1);
    check({tag, " done"},  o_done,   1'b0);
    tick();
    check({tag, " exc pulse"}, o_exc,    1'b0);
    check({tag, " req later"}, dmem_req, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // 1: SD aligned, gnt at once.
    do_store("sd", 3'b011, 64'h1000, 64'h1122334455667788, 8'hFF, 64'h1122334455667788);
    // 2: SB into byte 5.
    do_store("sb", 3'b000, 64'h1005, 64'h00000000000000AB, 8'h20, 64'h0000AB0000000000);
    do_store("sh", 3'b001, 64'h1006, 64'h000000000000BEEF, 8'hC0, 64'hBEEF000000000000);
    do_store("sw", 3'b010, 64'h1004, 64'hFFFFFFFFCAFEBABE, 8'hF0, 64'hCAFEBABE00000000);

    // 3: LB / LBU of byte 3 = 0x80.
    do_load("lb",  3'b000, 64'h2003, 5'd3, 64'h1122334480665577, 0, 1'b0, 8'h08, 64'hFFFFFFFFFFFFFF80);
    do_load("lbu", 3'b100, 64'h2003, 5'd4, 64'h1122334480665577, 0, 1'b0, 8'h08, 64'h0000000000000080);

    // Write-back registers hold across a store.
    do_store("sb2", 3'b000, 64'h1000, 64'h5A, 8'h01, 64'h5A);
    check("wb hold after store", o_wb_data, 64'h80);

    // 4: misaligned LW, and LD with gnt held off 3 cycles.
    do_exc("lw misalign", 1'b1, 1'b0, 3'b010, 64'h2002);
    do_load("ld", 3'b011, 64'h4008, 5'd9, 64'hDEADBEEFCAFEF00D, 3, 1'b0, 8'hFF, 64'hDEADBEEFCAFEF00D);

    // 5: LW sign extension, plus LWU and halfword variants.
    do_load("lw",  3'b010, 64'h3004, 5'd17, 64'h8765432100000000, 0, 1'b1, 8'hF0, 64'hFFFFFFFF87654321);
    do_load("lwu", 3'b110, 64'h3004, 5'd18, 64'h8765432100000000, 1, 1'b0, 8'hF0, 64'h0000000087654321);
    do_load("lh",  3'b001, 64'h2006, 5'd20, 64'h8001123456789ABC, 0, 1'b0, 8'hC0, 64'hFFFFFFFFFFFF8001);
    do_load("lhu", 3'b101, 64'h2006, 5'd21, 64'h8001123456789ABC, 0, 1'b0, 8'hC0, 64'h0000000000008001);

    // Illegal requests and misaligned store.
    do_exc("rd+wr",   1'b1, 1'b1, 3'b000, 64'h1000);
    do_exc("f3 111",  1'b1, 1'b0, 3'b111, 64'h1000);
    do_exc("sh odd",  1'b0, 1'b1, 3'b001, 64'h1001);
    do_exc("sd off4", 1'b0, 1'b1, 3'b011, 64'h1004);

    // No-op: valid without rd/wr.
    i_valid = 1'b1; i_funct3 = 3'b111; i_addr = 64'h3;
    tick();
    i_valid = 1'b0; i_funct3 = '0; i_addr = '0;
    check("noop exc",   o_exc,    1'b0);
    check("noop req",   dmem_req, 1'b0);
    check("noop ready", o_ready,  1'b1);
    check("noop done",  o_done,   1'b0);

    // 6: reset while waiting for rvalid, then a stale response.
    i_valid = 1'b1; i_mem_rd = 1'b1; i_funct3 = 3'b011; i_addr = 64'h5000; i_rd = 5'd7;
    tick();
    i_valid = 1'b0; i_mem_rd = 1'b0; i_addr = '0; i_funct3 = '0; i_rd = '0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check("rst pre wait", o_ready, 1'b0);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid rst");
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 64'h0123456789ABCDEF;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    check("stale wbvalid", o_wb_valid, 1'b0);
    check("stale done",    o_done,     1'b0);
    check("stale wbdata",  o_wb_data,  64'h0);
    check("stale ready",   o_ready,    1'b1);
    tick();
    check("stale wbvalid2", o_wb_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
